lru_state_array: RTL and testbench
==================================

// Module: lru_state_array
// PURPOSE
//  Per-set LRU state storage for a set-associative cache. It sits between the tag
//  pipeline and the combinational LRU update/replace logic. On a lookup it returns
//  the set's LRU bits (repl_lru input of the update logic). It accepts bit-masked
//  writes (new_lru / new_lru_bit_mask), forwards a same-cycle write into the read
//  data, and runs an init/invalidate sweep that walks every set.
// PARAMETERS
//  LRU_BITS  6    LRU bits per set (6 = 4-way pairwise, 1 = 2-way)
//  SET_N     256  number of sets
//  IDX_W     8    set index width, SET_N == 2**IDX_W
//  CLR_VAL   0    LRU_BITS value written to every set by the sweep
// PORTS
//  clk          in   1         clock
//  reset        in   1         asynchronous reset, active high
//  ready        out  1         1 = read/write/clear requests accepted this cycle
//  rd_valid     in   1         lookup request
//  rd_idx       in   IDX_W     lookup set index
//  rd_lru       out  LRU_BITS  LRU state of the set, 1 cycle after the request
//  rd_lru_valid out  1         rd_lru qualifier
//  rd_par_err   out  1         parity mismatch on rd_lru (LRU_PARITY_EN only)
//  wr_en        in   1         write request
//  wr_idx       in   IDX_W     write set index
//  wr_data      in   LRU_BITS  new LRU bits
//  wr_mask      in   LRU_BITS  per-bit write enable
//  clr_req      in   1         start an invalidate sweep (pulse)
//  clr_busy     out  1         sweep in progress
//  clr_done     out  1         1-cycle pulse after the last set is written
// BEHAVIOUR
//  - Storage: SET_N x LRU_BITS flops. Array contents are not reset; the sweep initialises them.
//  - Reset values: state = SWEEP, sweep ptr = 0, ready = 0, rd_lru = 0,
//    rd_lru_valid = 0, rd_par_err = 0, clr_busy = 1, clr_done = 0.
//  - FSM states:
//    - IDLE: ready = 1.
//    - SWEEP: ready = 0, clr_busy = 1; writes CLR_VAL to the set at ptr once per cycle.
//      - ptr == SET_N-1: go to IDLE and pulse clr_done on the next cycle.
//      - ptr wraps to 0 on sweep start.
//    - Reset exit enters SWEEP, so ready stays 0 for exactly SET_N cycles.
//  - IDLE with clr_req = 1: go to SWEEP next cycle. Clear has priority; any rd_valid
//    or wr_en in the same cycle is dropped (rd_lru_valid stays 0).
//  - clr_req while busy is ignored. It does not restart or extend the sweep.
//  - Requests while ready = 0 are ignored. Upstream holds its request until ready = 1.
//  - Write: when ready & wr_en, at the clock edge
//    entry <= (entry & ~wr_mask) | (wr_data & wr_mask). A wr_mask of all zeros is a no-op.
//  - Read: when ready & rd_valid, the entry is sampled at edge T.
//    rd_lru and rd_lru_valid are asserted during cycle T+1 only.
//    rd_lru holds its last value when rd_lru_valid = 0.
//  - Bypass: read and write in the same cycle to the same index:
//    rd_lru = (old & ~wr_mask) | (wr_data & wr_mask), i.e. write-first.
//    Different indices have no interaction.
//  - Reset asserted mid-sweep or mid-read aborts it. After deassert the sweep
//    restarts at ptr 0, and rd_lru_valid is 0 until a new read.
// CONFIGURATION
//  LRU_PARITY_EN defined:
//   - Each entry stores one extra even-parity bit over its LRU bits.
//   - Writes and the sweep recompute parity from the merged value.
//   - On a read mismatch, rd_par_err = 1 alongside rd_lru_valid and rd_lru is forced
//     to 0, so way 0 is picked for replacement.
//  LRU_PARITY_EN undefined: no parity storage; rd_par_err is tied to 0.
// TESTING
//  1. Release reset -> ready = 0 and clr_busy = 1 for 256 cycles, then ready = 1.
//     Read idx 5 -> rd_lru = 6'b000000 with rd_lru_valid 1 cycle later.
//  2. Write idx 3, data 6'b111000, mask 6'b111000; read idx 3 -> 6'b111000.
//     Then write data 6'b000110, mask 6'b000110; read idx 3 -> 6'b111110.
//  3. Idx 7 holds 6'b000001. Same cycle: write idx 7 data 6'b110000 mask 6'b110000
//     and read idx 7 -> rd_lru = 6'b110001 next cycle. Read idx 8 alongside is unaffected.
//  4. clr_req with writes pending in the same cycle -> writes dropped, 256 busy cycles,
//     single clr_done pulse. A clr_req mid-sweep causes no extension. All sets read 0 after.
//  5. Assert reset when the sweep ptr is 100 -> after deassert, ready = 0 for a full
//     256 cycles and rd_lru_valid = 0.
//  6. (LRU_PARITY_EN) Flip a stored bit of idx 9 via hierarchical force; read idx 9
//     -> rd_par_err = 1, rd_lru = 0. With the macro undefined, rd_par_err stays 0.

Source files
------------

// File: rtl/lru_state_array.sv
// Per-set LRU state storage with masked writes, write-first bypass and an init sweep.
// Optional feature: define LRU_PARITY_EN to store and check one even-parity bit per set.
module lru_state_array #(
  parameter int                  LRU_BITS = 6,
  parameter int                  SET_N    = 256,
  parameter int                  IDX_W    = 8,
  parameter logic [LRU_BITS-1:0] CLR_VAL  = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                rd_valid,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [LRU_BITS-1:0] rd_lru,
  output logic                rd_lru_valid,
  output logic                rd_par_err,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [LRU_BITS-1:0] wr_data,
  input  logic [LRU_BITS-1:0] wr_mask,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

`ifdef LRU_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int               STORE_W  = LRU_BITS + PAR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic              clr_done_reg, clr_done_next;

  logic [LRU_BITS-1:0] rd_lru_reg;
  logic                rd_lru_valid_reg;
  logic                rd_par_err_reg;

  logic [STORE_W-1:0]  mem [SET_N];

  logic                accept, rd_fire, wr_fire;
  logic [LRU_BITS-1:0] wr_old, wr_merged, store_lru;
  logic [STORE_W-1:0]  store_word, rd_word;
  logic                store_en;
  logic [IDX_W-1:0]    store_idx;
  logic                rd_err;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == LAST_IDX) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: state_next = SWEEP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= SWEEP;
      ptr_reg      <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      clr_done_reg <= clr_done_next;
    end
  end

  // A clear request in IDLE swallows any read or write issued alongside it.
  assign ready   = (state_reg == IDLE);
  assign accept  = ready & ~clr_req;
  assign rd_fire = accept & rd_valid;
  assign wr_fire = accept & wr_en;

  assign wr_old    = mem[wr_idx][LRU_BITS-1:0];
  assign wr_merged = (wr_old & ~wr_mask) | (wr_data & wr_mask);

  always_comb begin
    store_en  = 1'b0;
    store_idx = wr_idx;
    store_lru = wr_merged;
    if (state_reg == SWEEP) begin
      store_en  = 1'b1;
      store_idx = ptr_reg;
      store_lru = CLR_VAL;
    end else if (wr_fire) begin
      store_en = 1'b1;
    end
  end

`ifdef LRU_PARITY_EN
  assign store_word = {^store_lru, store_lru};
`else
  assign store_word = store_lru;
`endif

  // Storage is deliberately not reset; the sweep initialises every set.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[store_idx] <= store_word;
    end
  end

  // Write-first bypass: a same-index write in the same cycle shows up in the read data.
  assign rd_word = (wr_fire && (wr_idx == rd_idx)) ? store_word : mem[rd_idx];

`ifdef LRU_PARITY_EN
  assign rd_err = ^rd_word;
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_lru_reg       <= '0;
      rd_lru_valid_reg <= 1'b0;
      rd_par_err_reg   <= 1'b0;
    end else begin
      rd_lru_valid_reg <= rd_fire;
      rd_par_err_reg   <= rd_fire & rd_err;
      if (rd_fire) begin
        rd_lru_reg <= rd_err ? '0 : rd_word[LRU_BITS-1:0];
      end
    end
  end

  assign rd_lru       = rd_lru_reg;
  assign rd_lru_valid = rd_lru_valid_reg;
  assign rd_par_err   = rd_par_err_reg;
  assign clr_busy     = (state_reg == SWEEP);
  assign clr_done     = clr_done_reg;

endmodule

// File: tb/tb_lru_state_array.sv
// Scoreboard bench for lru_state_array: the driver queues expected read data,
// a negedge monitor pops and compares whenever rd_lru_valid is seen.
module tb_lru_state_array;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic       rd_valid;
  logic [7:0] rd_idx;
  logic [5:0] rd_lru;
  logic       rd_lru_valid;
  logic       rd_par_err;
  logic       wr_en;
  logic [7:0] wr_idx;
  logic [5:0] wr_data;
  logic [5:0] wr_mask;
  logic       clr_req;
  logic       clr_busy;
  logic       clr_done;

  lru_state_array dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .rd_valid     (rd_valid),
    .rd_idx       (rd_idx),
    .rd_lru       (rd_lru),
    .rd_lru_valid (rd_lru_valid),
    .rd_par_err   (rd_par_err),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] lru;
    logic       perr;
    logic [7:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one line per completed read.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rd_lru_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_lru_valid", 32'(rd_lru_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("rd idx %0d: rd_lru=%b par_err=%b (want %b/%b)", e.idx, rd_lru, rd_par_err, e.lru, e.perr);
        check("rd_lru", 32'(rd_lru), 32'(e.lru));
        check("rd_par_err", 32'(rd_par_err), 32'(e.perr));
      end
    end
  end

  // One request cycle, driven from a negedge; returns at the next negedge.
  task automatic op(input bit rd, input int ridx, input bit wr, input int widx,
                    input logic [5:0] wd, input logic [5:0] wm, input bit clr,
                    input bit expect_rd, input logic [5:0] exp_lru, input bit exp_perr);
    exp_t e;
    rd_valid = rd;
    rd_idx   = 8'(ridx);
    wr_en    = wr;
    wr_idx   = 8'(widx);
    wr_data  = wd;
    wr_mask  = wm;
    clr_req  = clr;
    if (expect_rd) begin
      e.lru  = exp_lru;
      e.perr = exp_perr;
      e.idx  = 8'(ridx);
      exp_q.push_back(e);
    end
    @(negedge clk);
    rd_valid = 1'b0;
    wr_en    = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [5:0] exp_lru);
    op(1'b1, idx, 1'b0, 0, 6'd0, 6'd0, 1'b0, 1'b1, exp_lru, 1'b0);
  endtask

  task automatic wr(input int idx, input logic [5:0] d, input logic [5:0] m);
    op(1'b0, 0, 1'b1, idx, d, m, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  // Counts not-ready cycles until ready (bounded), optionally pulsing clr_req mid-sweep.
  task automatic wait_sweep(input int inj, input string tag);
    int busy = 0;
    int done = 0;
    int bad  = 0;
    while (!ready && busy < 1000) begin
      busy++;
      if (clr_busy !== 1'b1) bad++;
      if (clr_done === 1'b1) done++;
      clr_req = (busy == inj);
      @(negedge clk);
    end
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (clr_done === 1'b1) done++;
      @(negedge clk);
    end
    $display("sweep %s: %0d not-ready cycles, %0d clr_done pulses", tag, busy, done);
    check({tag, "_busy_cycles"}, 32'(busy), 32'd256);
    check({tag, "_clr_done_pulses"}, 32'(done), 32'd1);
    check({tag, "_clr_busy_low_in_sweep"}, 32'(bad), 32'd0);
    check({tag, "_clr_busy_after"}, 32'(clr_busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rd_valid = 1'b0;
    rd_idx   = '0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    wr_mask  = '0;
    clr_req  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rd_lru", 32'(rd_lru), 32'd0);
    check("rst_rd_lru_valid", 32'(rd_lru_valid), 32'd0);
    check("rst_rd_par_err", 32'(rd_par_err), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd1);
    check("rst_clr_done", 32'(clr_done), 32'd0);

    // 1: power-up sweep, then read idx 5
    reset = 1'b0;
    wait_sweep(0, "init");
    rd(5, 6'b000000);

    // 2: masked writes accumulate; all-zero mask is a no-op
    wr(3, 6'b111000, 6'b111000);
    rd(3, 6'b111000);
    wr(3, 6'b000110, 6'b000110);
    rd(3, 6'b111110);
    wr(3, 6'b111111, 6'b000000);
    rd(3, 6'b111110);

    // 3: write-first bypass on same index, none on a different index
    wr(7, 6'b000001, 6'b111111);
    wr(8, 6'b101010, 6'b111111);
    op(1'b1, 7, 1'b1, 7, 6'b110000, 6'b110000, 1'b0, 1'b1, 6'b110001, 1'b0);
    op(1'b1, 8, 1'b1, 7, 6'b001100, 6'b001100, 1'b0, 1'b1, 6'b101010, 1'b0);
    rd(7, 6'b111101);

    // 4: clear drops same-cycle read/write; mid-sweep clr_req does not extend it
    op(1'b1, 3, 1'b1, 20, 6'b111111, 6'b111111, 1'b1, 1'b0, 6'd0, 1'b0);
    wait_sweep(50, "clr");
    for (int i = 0; i < 256; i++) rd(i, 6'b000000);
    @(negedge clk);

    // 5: reset at sweep ptr 100 restarts a full sweep
    wr(12, 6'b010101, 6'b111111);
    op(1'b0, 0, 1'b0, 0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midsweep_rst_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    wait_sweep(0, "rst100");
    check("rst100_rd_lru_valid", 32'(rd_lru_valid), 32'd0);
    rd(12, 6'b000000);

    // 5b: reset right after a read is sampled aborts the valid pulse
    wr(4, 6'b100001, 6'b111111);
    rd_valid = 1'b1;
    rd_idx   = 8'd4;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midread_rd_lru_valid", 32'(rd_lru_valid), 32'd0);
    check("midread_rd_lru", 32'(rd_lru), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_sweep(0, "rstread");
    check("rstread_rd_lru_valid", 32'(rd_lru_valid), 32'd0);

    // 6: parity error path (or no parity error when the feature is off)
    wr(9, 6'b001011, 6'b111111);
`ifdef LRU_PARITY_EN
    dut.mem[9][0] = ~dut.mem[9][0];
    op(1'b1, 9, 1'b0, 0, 6'd0, 6'd0, 1'b0, 1'b1, 6'b000000, 1'b1);
`else
    op(1'b1, 9, 1'b0, 0, 6'd0, 6'd0, 1'b0, 1'b1, 6'b001011, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
